// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//   SPI slave, one WIDTH-bit frame per word, MSB first. The master idles sclk
//   low; the slave samples mosi on sclk falling edges and drives miso after
//   sclk rising edges. All SPI pins are oversampled by clk through
//   SYNC_STAGES-deep synchronizers, so the master's sclk phases must each last
//   at least SYNC_STAGES+2 clk periods.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   sclk, mosi   SPI clock and data from the master
//   ss           slave select, active low
//   miso         serial data to the master
//   miso_oe      miso drive enable, high while a frame is selected
//   tx_data      word to send in a later frame
//   tx_load      strobe writing tx_data into the TX holding register
//   tx_ready     holding register empty
//   rx_data      last complete received word
//   rx_valid     one-cycle pulse when rx_data updates
//   frame_err    one-cycle pulse when ss deasserts mid-word
//   tx_underrun  one-cycle pulse when a word starts with nothing to send
// -----------------------------------------------------------------------------
module spi_slave #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclk,
   input  logic             mosi,
   input  logic             ss,
   output logic             miso,
   output logic             miso_oe,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_load,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             frame_err,
   output logic             tx_underrun
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   // ---------------------------------------------------------------------------
   // Input synchronizers and edge detection
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic                   sclk_d;
   logic                   ss_d;
   logic [SYNC_STAGES:0]   flush;
   logic                   armed;

   logic sclk_s, mosi_s, ss_s;
   logic sclk_rise, sclk_fall, ss_rise, ss_fall;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];
   assign ss_s   = ss_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_sync   <= '1;
         sclk_d    <= 1'b0;
         ss_d      <= 1'b1;
         flush     <= '0;
         armed     <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
         sclk_d    <= sclk_s;
         ss_d      <= ss_s;
         flush     <= {flush[SYNC_STAGES-1:0], 1'b1};
         // The ss synchronizer resets to "deselected", so if the master still
         // holds ss low across a reset the chain would show a phantom falling
         // edge. Frames are only accepted once ss has been seen high with the
         // synchronizer holding real pin samples.
         armed     <= armed | (flush[SYNC_STAGES] & ss_s & ss_d);
      end
   end

   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign ss_rise   = ss_s & ~ss_d;
   assign ss_fall   = ~ss_s & ss_d & armed;

   // ---------------------------------------------------------------------------
   // Frame FSM
   // ---------------------------------------------------------------------------
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t state, state_nxt;
   logic   frame_start, frame_end, sample, drive;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      sample      = 1'b0;
      drive       = 1'b0;
      case (state)
         IDLE: begin
            if (ss_fall) begin
               state_nxt   = SHIFT;
               frame_start = 1'b1;
            end
         end
         SHIFT: begin
            // Deselect wins over any coincident sclk edge.
            if (ss_rise) begin
               state_nxt = IDLE;
               frame_end = 1'b1;
            end else if (sclk_fall) begin
               sample = 1'b1;
            end else if (sclk_rise) begin
               drive = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // TX holding register
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] hold;
   logic             hold_full;
   logic [CW-1:0]    bit_cnt;
   logic             word_done;
   logic             copy;
   logic             load_ok;
   logic [WIDTH-1:0] next_word;

   assign word_done = sample & (bit_cnt == LAST_BIT);
   assign copy      = (frame_start | word_done) & hold_full;
   // A copy frees the slot in the same cycle, so a coincident load is kept.
   assign load_ok   = tx_load & (~hold_full | copy);
   assign next_word = hold_full ? hold : '0;
   assign tx_ready  = ~hold_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold      <= '0;
         hold_full <= 1'b0;
      end else begin
         if (load_ok) hold <= tx_data;
         hold_full <= (hold_full & ~copy) | load_ok;
      end
   end

   // ---------------------------------------------------------------------------
   // Shift registers and outputs
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] tx_sr;
   logic [WIDTH-2:0] rx_sr;
   logic [WIDTH-1:0] rx_next;
   logic             und_pend;

   assign rx_next = {rx_sr, mosi_s};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_sr       <= '0;
         rx_sr       <= '0;
         bit_cnt     <= '0;
         miso        <= 1'b0;
         miso_oe     <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         tx_underrun <= 1'b0;
         und_pend    <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         tx_underrun <= 1'b0;
         if (frame_start) begin
            tx_sr       <= next_word;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            miso        <= next_word[WIDTH-1];
            miso_oe     <= 1'b1;
            tx_underrun <= ~hold_full;
            und_pend    <= 1'b0;
         end else if (frame_end) begin
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
            bit_cnt  <= '0;
            rx_sr    <= '0;
            und_pend <= 1'b0;
            if (bit_cnt != '0) frame_err <= 1'b1;
         end else if (sample) begin
            rx_sr <= rx_next[WIDTH-2:0];
            if (word_done) begin
               rx_data  <= rx_next;
               rx_valid <= 1'b1;
               bit_cnt  <= '0;
               tx_sr    <= next_word;
               // The reload happens at the wrap, but the new word only really
               // begins once the master clocks it. An empty reload is reported
               // on that first rising edge, so a frame that ends exactly on a
               // word boundary does not report a spurious underrun.
               und_pend <= ~hold_full;
            end else begin
               bit_cnt <= bit_cnt + CW'(1);
            end
         end else if (drive) begin
            // Rising edge k of the word (bit_cnt == k) presents bit WIDTH-1-k.
            miso <= tx_sr[LAST_BIT - bit_cnt];
            if (und_pend) begin
               tx_underrun <= 1'b1;
               und_pend    <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

   localparam int W    = 16;
   localparam int HALF = 6;   // clk periods per sclk phase

   logic         clk = 1'b0;
   logic         rst, sclk, mosi, ss, tx_load;
   logic [W-1:0] tx_data;
   logic         miso, miso_oe, tx_ready, rx_valid, frame_err, tx_underrun;
   logic [W-1:0] rx_data;

   spi_slave #(.WIDTH(W), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .ss(ss),
      .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .frame_err(frame_err), .tx_underrun(tx_underrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Pulse monitor
   int           n_rxv = 0, n_ferr = 0, n_und = 0;
   logic [W-1:0] rx_log[$];
   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin n_rxv++; rx_log.push_back(rx_data); end
      if (frame_err === 1'b1) n_ferr++;
      if (tx_underrun === 1'b1) n_und++;
   end

   // Reference model state
   bit           m_full = 0;
   logic [W-1:0] m_hold = '0;
   logic [W-1:0] m_rx = '0;
   int           exp_und;

   // Frame stimulus / capture
   logic [W-1:0] mw[4];
   logic [W-1:0] rw[4];
   logic [W-1:0] ew[4];
   int           load_bit = -1;
   int           rst_bit = -1;
   logic [W-1:0] load_val;
   logic         ready_at_start, oe_at_start, oe_at_end;
   bit           aborted;
   int           d_rxv, d_ferr, d_und;

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tb_load(input logic [W-1:0] v);
      tx_data = v;
      tx_load = 1'b1;
      if (!m_full) begin m_full = 1; m_hold = v; end
      wait_clk(1);
      tx_load = 1'b0;
   endtask

   // A word start consumes the holding register, or zeros if it is empty.
   task automatic m_word_start(output logic [W-1:0] w, output logic empty);
      empty  = !m_full;
      w      = m_full ? m_hold : '0;
      m_full = 0;
   endtask

   task automatic run_frame(input int nbits);
      logic [W-1:0] nxt;
      logic         e, nxt_e;
      int           w, k;
      exp_und = 0;
      aborted = 0;
      nxt     = '0;
      nxt_e   = 1'b0;
      for (int i = 0; i < 4; i++) begin rw[i] = '0; ew[i] = '0; end
      ss = 1'b0;
      m_word_start(ew[0], e);
      if (e) exp_und++;
      wait_clk(HALF);
      ready_at_start = tx_ready;
      oe_at_start    = miso_oe;
      for (int b = 0; b < nbits; b++) begin
         w = b / W;
         k = b % W;
         if (k == 0 && b != 0 && !aborted) begin
            ew[w] = nxt;
            if (nxt_e) exp_und++;
         end
         sclk = 1'b1;
         mosi = mw[w][W-1-k];
         if (b == load_bit) begin
            tb_load(load_val);
            wait_clk(HALF - 1);
         end else if (b == rst_bit) begin
            rst = 1'b1;
            m_full = 0;
            m_rx = '0;
            aborted = 1;
            wait_clk(2);
            rst = 1'b0;
            wait_clk(HALF - 2);
         end else begin
            wait_clk(HALF);
         end
         rw[w][W-1-k] = miso;
         sclk = 1'b0;
         wait_clk(HALF);
         if (k == W - 1 && !aborted) m_word_start(nxt, nxt_e);
      end
      oe_at_end = miso_oe;
      ss = 1'b1;
      wait_clk(2 * HALF);
   endtask

   task automatic do_frame(input string tag, input int nbits);
      int           r0, f0, u0, nw;
      logic [W-1:0] got;
      r0 = n_rxv; f0 = n_ferr; u0 = n_und;
      nw = nbits / W;
      run_frame(nbits);
      d_rxv = n_rxv - r0; d_ferr = n_ferr - f0; d_und = n_und - u0;
      chk({tag, " oe_start"}, oe_at_start, 1);
      for (int i = 0; i < nw; i++) chk($sformatf("%s miso_w%0d", tag, i), rw[i], ew[i]);
      chk({tag, " rx_valid_cnt"}, d_rxv, nw);
      for (int i = 0; i < nw; i++) begin
         got = (rx_log.size() > 0) ? rx_log.pop_front() : 'x;
         chk($sformatf("%s rx_w%0d", tag, i), got, mw[i]);
      end
      rx_log.delete();
      chk({tag, " frame_err_cnt"}, d_ferr, (nbits % W != 0) ? 1 : 0);
      chk({tag, " underrun_cnt"}, d_und, exp_und);
      if (nw > 0) m_rx = mw[nw-1];
      chk({tag, " rx_data"}, rx_data, m_rx);
      chk({tag, " tx_ready"}, tx_ready, m_full ? 0 : 1);
      chk({tag, " oe_end"}, miso_oe, 0);
      chk({tag, " miso_end"}, miso, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int r0, f0, u0, nb, sel;
      rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ss = 1'b1; tx_load = 1'b0; tx_data = '0;
      wait_clk(3);
      // Reset values
      chk("rst miso", miso, 0);
      chk("rst miso_oe", miso_oe, 0);
      chk("rst tx_ready", tx_ready, 1);
      chk("rst rx_data", rx_data, 0);
      chk("rst rx_valid", rx_valid, 0);
      chk("rst frame_err", frame_err, 0);
      chk("rst tx_underrun", tx_underrun, 0);
      rst = 1'b0;
      wait_clk(8);

      // Basic exchange
      tb_load(16'hA5C3);
      chk("basic tx_ready_after_load", tx_ready, 0);
      mw[0] = 16'h1234;
      do_frame("basic", 16);
      chk("basic master_rx", rw[0], 16'hA5C3);
      chk("basic ready_at_start", ready_at_start, 1);
      chk("basic rx_data", rx_data, 16'h1234);
      chk("basic rx_valid_one", d_rxv, 1);

      // Underrun
      mw[0] = 16'($urandom);
      do_frame("undr", 16);
      chk("undr master_rx", rw[0], 16'h0000);
      chk("undr pulse_one", d_und, 1);

      // Back-to-back words, second word loaded during the first
      tb_load(16'hFFFF);
      mw[0] = 16'($urandom); mw[1] = 16'($urandom);
      load_bit = 5; load_val = 16'h0F0F;
      do_frame("b2b", 32);
      load_bit = -1;
      chk("b2b word0", rw[0], 16'hFFFF);
      chk("b2b word1", rw[1], 16'h0F0F);
      chk("b2b rx_valid_two", d_rxv, 2);

      // Partial word then full frame
      mw[0] = 16'($urandom);
      do_frame("part", 7);
      chk("part frame_err_one", d_ferr, 1);
      chk("part rx_valid_none", d_rxv, 0);
      mw[0] = 16'($urandom);
      tb_load(16'($urandom));
      do_frame("after_part", 16);

      // Load while full is dropped
      tb_load(16'h1111);
      tb_load(16'h2222);
      chk("dbl tx_ready", tx_ready, 0);
      mw[0] = 16'($urandom);
      do_frame("dbl", 16);
      chk("dbl master_rx", rw[0], 16'h1111);

      // Reset mid-frame, ss still low through release
      tb_load(16'h5555);
      mw[0] = 16'($urandom);
      rst_bit = 9;
      r0 = n_rxv; f0 = n_ferr; u0 = n_und;
      run_frame(16);
      rst_bit = -1;
      chk("rstmid rx_valid_none", n_rxv - r0, 0);
      chk("rstmid frame_err_none", n_ferr - f0, 0);
      chk("rstmid underrun_none", n_und - u0, 0);
      chk("rstmid oe_after_rst", oe_at_end, 0);
      chk("rstmid rx_data", rx_data, 0);
      chk("rstmid tx_ready", tx_ready, 1);
      chk("rstmid miso", miso, 0);
      rx_log.delete();
      mw[0] = 16'hBEEF;
      do_frame("post_rst", 16);
      chk("post_rst rx_data", rx_data, 16'hBEEF);

      // Randomized frames
      for (int i = 0; i < 8; i++) begin
         if ($urandom_range(0, 1) == 1) tb_load(16'($urandom));
         sel = int'($urandom_range(0, 3));
         nb  = (sel < 2) ? 16 : (sel == 2) ? 32 : int'($urandom_range(1, 15));
         for (int j = 0; j < 2; j++) mw[j] = 16'($urandom);
         if (nb == 32 && $urandom_range(0, 1) == 1) begin
            load_bit = int'($urandom_range(2, 13));
            load_val = 16'($urandom);
         end
         do_frame($sformatf("rnd%0d", i), nb);
         load_bit = -1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
